// File: rtl/shapool_pkg.sv
// Shared constants and types for the hashing pool front-end.
// The SPI receiver and its synchroniser take their defaults from here.
package shapool_pkg;

    localparam int unsigned JOB_WIDTH       = 352;
    localparam int unsigned JOB_COUNT_WIDTH = 9;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    // Pin-level events for one clk_in cycle, already qualified by chip select where relevant.
    typedef struct packed {
        logic sck_rise;
        logic sck_fall;
        logic cs_start;
        logic cs_end;
    } spi_edges_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchroniser for an asynchronous pin into the clk_in domain.
// Every stage resets to RESET_VALUE so an idle pin level is seen from the first cycle.
module sync_2ff
    import shapool_pkg::*;
#(
    parameter logic        RESET_VALUE = 1'b0,
    parameter int unsigned STAGES      = SPI_SYNC_STAGES
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            sync_q <= {STAGES{RESET_VALUE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/spi_sync_rx.sv
// Oversampled SPI mode-0 slave receiver: synchronise pins, detect sck/cs edges,
// shift a job word MSB first, strobe it out at frame end and re-drive the MSB for daisy chains.
module spi_sync_rx
    import shapool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = JOB_WIDTH,
    parameter int unsigned COUNT_WIDTH = JOB_COUNT_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  sck_in,
    input  logic                  sdi_in,
    input  logic                  cs_n_in,
    output logic                  sdo_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  short_frame_out,
    output logic                  busy_out
);

    localparam logic [COUNT_WIDTH-1:0] CNT_FULL = COUNT_WIDTH'(DATA_WIDTH);

    logic s_sck;
    logic s_sdi;
    logic s_cs_n;

    sync_2ff #(
        .RESET_VALUE (1'b0)
    ) u_sync_sck (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .d_in     (sck_in),
        .q_out    (s_sck)
    );

    sync_2ff #(
        .RESET_VALUE (1'b0)
    ) u_sync_sdi (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .d_in     (sdi_in),
        .q_out    (s_sdi)
    );

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync_cs_n (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .d_in     (cs_n_in),
        .q_out    (s_cs_n)
    );

    logic                   d_sck_q;
    logic                   d_sdi_q;
    logic                   d_cs_n_q;
    spi_edges_t             edges_d;
    spi_edges_t             edges_q;
    logic [DATA_WIDTH-1:0]  shift_d;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic [COUNT_WIDTH-1:0] cnt_d;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic                   sdo_d;
    logic                   sdo_q;
    logic [DATA_WIDTH-1:0]  data_d;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   valid_d;
    logic                   valid_q;
    logic                   short_d;
    logic                   short_q;
    logic                   busy_d;
    logic                   busy_q;

    // sck edges only count while cs is active; this also drops a rise landing in the cs_end cycle.
    always_comb begin
        edges_d.sck_rise = s_sck & ~d_sck_q & ~s_cs_n;
        edges_d.sck_fall = ~s_sck & d_sck_q & ~s_cs_n;
        edges_d.cs_start = ~s_cs_n & d_cs_n_q;
        edges_d.cs_end   = s_cs_n & ~d_cs_n_q;
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sdo_d   = sdo_q;
        data_d  = data_q;
        valid_d = 1'b0;
        short_d = 1'b0;
        busy_d  = ~d_cs_n_q;

        // Old contents are kept on cs_start so they stream out behind the new frame.
        if (edges_q.cs_start) begin
            cnt_d = '0;
            sdo_d = shift_q[DATA_WIDTH-1];
        end

        if (edges_q.sck_rise) begin
            shift_d = {shift_q[DATA_WIDTH-2:0], d_sdi_q};
            if (cnt_d != CNT_FULL) begin
                cnt_d = cnt_d + COUNT_WIDTH'(1);
            end
        end

        if (edges_q.sck_fall) begin
            sdo_d = shift_q[DATA_WIDTH-1];
        end

        if (edges_q.cs_end) begin
            if (cnt_q == CNT_FULL) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else if (cnt_q != '0) begin
                short_d = 1'b1;
            end
        end
    end

    // The edge terms are registered together with sdi so shift data stays aligned to its rise.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            d_sck_q  <= 1'b0;
            d_sdi_q  <= 1'b0;
            d_cs_n_q <= 1'b1;
            edges_q  <= '0;
        end else begin
            d_sck_q  <= s_sck;
            d_sdi_q  <= s_sdi;
            d_cs_n_q <= s_cs_n;
            edges_q  <= edges_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            shift_q <= '0;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            short_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            short_q <= short_d;
            busy_q  <= busy_d;
        end
    end

    assign sdo_out         = sdo_q;
    assign data_out        = data_q;
    assign data_valid_out  = valid_q;
    assign short_frame_out = short_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_spi_sync_rx.sv
// Randomised bench for spi_sync_rx: a bit-history model predicts sdo, data words and strobes.
module tb_spi_sync_rx;

    localparam int W = 352;

    logic         clk_in = 1'b0;
    logic         reset_in = 1'b1;
    logic         sck_in = 1'b0;
    logic         sdi_in = 1'b0;
    logic         cs_n_in = 1'b1;
    logic         sdo_out;
    logic [W-1:0] data_out;
    logic         data_valid_out;
    logic         short_frame_out;
    logic         busy_out;

    always #5 clk_in = ~clk_in;

    spi_sync_rx dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .sck_in          (sck_in),
        .sdi_in          (sdi_in),
        .cs_n_in         (cs_n_in),
        .sdo_out         (sdo_out),
        .data_out        (data_out),
        .data_valid_out  (data_valid_out),
        .short_frame_out (short_frame_out),
        .busy_out        (busy_out)
    );

    typedef enum {KNone, KValid, KShort} kind_e;

    int           n_checks = 0;
    int           n_fail = 0;
    int           n_valid = 0;
    int           n_short = 0;
    bit           hist[$];
    int           frame_base = 0;
    int           nrise = 0;
    kind_e        pend_kind = KNone;
    logic [W-1:0] pend_data = '0;
    logic [W-1:0] exp_data = '0;
    logic [4:0]   cs_h = 5'b11111;
    logic [4:0]   rs_h = 5'b11111;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit bit_at(input int idx);
        if (idx < 0 || idx >= hist.size()) return 1'b0;
        return hist[idx];
    endfunction

    // Shift register contents = the last W bits received, newest in the LSB.
    function automatic logic [W-1:0] last_word();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = bit_at(hist.size() - 1 - i);
        return v;
    endfunction

    // Outputs reflect pin samples taken three edges earlier; any reset in that window masks them.
    initial begin : compare
        logic ev_end, exp_v, exp_s, exp_b;
        forever begin
            @(posedge clk_in);
            cs_h = {cs_h[3:0], cs_n_in};
            rs_h = {rs_h[3:0], reset_in};
            #1;
            ev_end = (rs_h == 5'b0) && cs_h[3] && !cs_h[4];
            exp_v  = ev_end && (pend_kind == KValid);
            exp_s  = ev_end && (pend_kind == KShort);
            exp_b  = (|rs_h[3:0]) ? 1'b0 : ~cs_h[3];
            if (rs_h[0]) exp_data = '0;
            else if (exp_v) exp_data = pend_data;
            check("data_valid", data_valid_out, exp_v);
            check("short_frame", short_frame_out, exp_s);
            check("busy", busy_out, exp_b);
            check("data_out", data_out, exp_data);
            if (data_valid_out) n_valid++;
            if (short_frame_out) n_short++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic start_frame();
        cs_n_in = 1'b0;
        frame_base = hist.size();
        nrise = 0;
        cycles(4);
    endtask

    // f_sck = f_clk/8; sdo is checked at the end of the high phase, before the next fall.
    task automatic send_bit(input bit b);
        sdi_in = b;
        cycles(4);
        sck_in = 1'b1;
        hist.push_back(b);
        nrise++;
        cycles(4);
        check("sdo", sdo_out, bit_at(frame_base + nrise - 1 - W));
        sck_in = 1'b0;
    endtask

    task automatic end_frame(input bit coincide, input bit b, input bit check_lat);
        cycles(4);
        sdi_in = b;
        pend_kind = (nrise >= W) ? KValid : ((nrise > 0) ? KShort : KNone);
        pend_data = last_word();
        if (coincide) sck_in = 1'b1;
        cs_n_in = 1'b1;
        if (check_lat) begin
            repeat (3) @(posedge clk_in);
            #1 check("latency_edge3", data_valid_out, 1'b0);
            @(posedge clk_in);
            #1 check("latency_edge4", data_valid_out, 1'b1);
            @(negedge clk_in);
            cycles(3);
        end else begin
            cycles(4);
        end
        sck_in = 1'b0;
        cycles(16);
    endtask

    task automatic pulse_reset();
        reset_in = 1'b1;
        cycles(2);
        reset_in = 1'b0;
        hist.delete();
        frame_base = 0;
        nrise = 0;
    endtask

    initial begin : stim
        logic [W-1:0]   a5w;
        logic [W-1:0]   xw;
        logic [W-1:0]   zw;
        logic [2*W-1:0] yw;
        logic [7:0]     a5;
        int             v0;
        int             s0;

        a5 = 8'hA5;
        a5w = {44{8'hA5}};
        cycles(5);
        reset_in = 1'b0;
        cycles(20);
        check("idle_data", data_out, 0);
        check("idle_sdo", sdo_out, 0);
        check("idle_busy", busy_out, 0);

        // 0xA5 repeated, with the strobe latency pinned explicitly.
        v0 = n_valid; s0 = n_short;
        start_frame();
        for (int i = 0; i < W; i++) send_bit(a5[7 - (i % 8)]);
        end_frame(1'b0, 1'b0, 1'b1);
        check("a5_data", data_out, a5w);
        check("a5_valid_count", n_valid - v0, 1);
        check("a5_short_count", n_short - s0, 0);

        // Frame X then a double-length frame Y: X streams out on sdo, data is Y's tail.
        for (int i = 0; i < W; i++) xw[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 2 * W; i++) yw[i] = 1'($urandom_range(0, 1));
        start_frame();
        for (int i = 0; i < W; i++) send_bit(xw[W - 1 - i]);
        end_frame(1'b0, 1'b0, 1'b0);
        check("x_data", data_out, xw);
        v0 = n_valid;
        start_frame();
        for (int i = 0; i < 2 * W; i++) send_bit(yw[2 * W - 1 - i]);
        end_frame(1'b0, 1'b0, 1'b0);
        check("y_data", data_out, yw[W-1:0]);
        check("y_valid_count", n_valid - v0, 1);

        // 100-bit frame is short and leaves data_out alone.
        v0 = n_valid; s0 = n_short;
        start_frame();
        for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)));
        end_frame(1'b0, 1'b0, 1'b0);
        check("short_count", n_short - s0, 1);
        check("short_valid_count", n_valid - v0, 0);
        check("short_data_kept", data_out, yw[W-1:0]);

        // Reset after 200 bits with cs held low; remaining 152 bits form a short frame.
        v0 = n_valid; s0 = n_short;
        start_frame();
        for (int i = 0; i < 200; i++) send_bit(1'($urandom_range(0, 1)));
        pulse_reset();
        for (int i = 0; i < 152; i++) send_bit(1'($urandom_range(0, 1)));
        end_frame(1'b0, 1'b0, 1'b0);
        check("rst_valid_count", n_valid - v0, 0);
        check("rst_short_count", n_short - s0, 1);
        check("rst_data", data_out, 0);

        // Full frame Z ending with an sck rise coincident with the cs_n rise.
        for (int i = 0; i < W; i++) zw[i] = 1'($urandom_range(0, 1));
        start_frame();
        for (int i = 0; i < W; i++) send_bit(zw[W - 1 - i]);
        end_frame(1'b1, ~zw[0], 1'b0);
        check("z_data", data_out, zw);

        // sck toggling with cs inactive must not shift or move sdo.
        for (int i = 0; i < 10; i++) begin
            sdi_in = 1'($urandom_range(0, 1));
            cycles(4);
            sck_in = 1'b1;
            cycles(4);
            sck_in = 1'b0;
        end
        cycles(8);
        check("idle_sck_sdo", sdo_out, zw[W-1]);
        check("idle_sck_data", data_out, zw);
        s0 = n_short;
        start_frame();
        for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)));
        end_frame(1'b0, 1'b0, 1'b0);
        check("after_idle_short_count", n_short - s0, 1);

        check("total_valid", n_valid, 4);
        check("total_short", n_short, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
